// File: rtl/axi_node_map_ctrl_pkg.sv
// Shared types and constants for the AXI node address-map controller.
//   - map_state_e : commit sequencer states
//   - ctrl_idx / status_idx : register indices that follow the start/end banks
//   - STATUS / CTRL bit positions
package axi_node_map_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DRAIN  = 2'd1,
        ST_COMMIT = 2'd2
    } map_state_e;

    // CTRL and STATUS sit directly after the start bank and the end bank.
    function automatic int ctrl_idx(input int nb_master);
        return 2 * nb_master;
    endfunction

    function automatic int status_idx(input int nb_master);
        return 2 * nb_master + 1;
    endfunction

    localparam int CTRL_COMMIT_BIT = 0;
    localparam int STATUS_BUSY_BIT = 0;
    localparam int STATUS_ERR_BIT  = 1;

endpackage

// File: rtl/axi_node_outstanding_cnt.sv
// Up/down outstanding-transaction counter for one channel pair of one slave port.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   inc_i      : request handshake (AW or AR)
//   dec_i      : completion handshake (B or R-last)
//   zero_o     : counter is 0
//   err_o      : single-cycle pulse on an overflow or underflow attempt
module axi_node_outstanding_cnt #(
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic inc_i,
    input  logic dec_i,
    output logic zero_o,
    output logic err_o
);
    localparam int CW = $clog2(MAX_OUTSTANDING + 1);

    logic [CW-1:0] cnt_q;
    logic          up, dn, at_max, at_zero;

    // Simultaneous inc and dec cancel out.
    assign up      = inc_i & ~dec_i;
    assign dn      = dec_i & ~inc_i;
    assign at_max  = (cnt_q == CW'(MAX_OUTSTANDING));
    assign at_zero = (cnt_q == '0);

    assign zero_o = at_zero;
    assign err_o  = (up & at_max) | (dn & at_zero);

    // Saturate instead of wrapping; the error pulse tells software.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt_q <= '0;
        else if (up && !at_max)
            cnt_q <= cnt_q + CW'(1);
        else if (dn && !at_zero)
            cnt_q <= cnt_q - CW'(1);
    end

endmodule

// File: rtl/axi_node_map_ctrl.sv
// Runtime address-map controller for the AXI node crossbar.
// Software writes shadow start/end registers over a req/gnt port, then writes
// CTRL bit0 to commit. The block raises block_o, waits until every slave port
// has no outstanding reads/writes and no handshake in flight, then copies
// shadow to active in a single cycle.
// Ports:
//   clk, rst_n                 : clock, async active-low reset
//   cfg_req_i/we/idx/wdata     : config request
//   cfg_gnt_o                  : request accepted (writes stall while busy)
//   cfg_rvalid_o/cfg_rdata_o   : response, one cycle after grant
//   aw/b/ar/r_last_hs_i        : per-slave-port handshake strobes
//   block_o                    : hold AW/AR ready low on all slave ports
//   start_addr_o/end_addr_o    : active map, entry i at [i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH]
//   busy_o                     : commit in progress
module axi_node_map_ctrl
    import axi_node_map_ctrl_pkg::*;
#(
    parameter int NB_MASTER       = 4,
    parameter int NB_SLAVE        = 4,
    parameter int AXI_ADDR_WIDTH  = 32,
    parameter int MAX_OUTSTANDING = 16,
    parameter int IDX_WIDTH       = $clog2(2 * NB_MASTER + 2)
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                cfg_req_i,
    input  logic                                cfg_we_i,
    input  logic [IDX_WIDTH-1:0]                cfg_idx_i,
    input  logic [AXI_ADDR_WIDTH-1:0]           cfg_wdata_i,
    output logic                                cfg_gnt_o,
    output logic                                cfg_rvalid_o,
    output logic [AXI_ADDR_WIDTH-1:0]           cfg_rdata_o,
    input  logic [NB_SLAVE-1:0]                 aw_hs_i,
    input  logic [NB_SLAVE-1:0]                 b_hs_i,
    input  logic [NB_SLAVE-1:0]                 ar_hs_i,
    input  logic [NB_SLAVE-1:0]                 r_last_hs_i,
    output logic                                block_o,
    output logic [NB_MASTER*AXI_ADDR_WIDTH-1:0] start_addr_o,
    output logic [NB_MASTER*AXI_ADDR_WIDTH-1:0] end_addr_o,
    output logic                                busy_o
);
    localparam int CTRL_IDX   = ctrl_idx(NB_MASTER);
    localparam int STATUS_IDX = status_idx(NB_MASTER);

    map_state_e state_q, state_d;

    logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] sh_start_q, sh_end_q;
    logic [NB_MASTER-1:0][AXI_ADDR_WIDTH-1:0] act_start_q, act_end_q;

    logic [NB_SLAVE-1:0] wr_zero, rd_zero, wr_err, rd_err;
    logic                busy, wr_en, rd_en, commit_req, err_clr, err_q, quiet;
    logic [AXI_ADDR_WIDTH-1:0] rd_mux;

    // ---------------- outstanding counters ----------------
    for (genvar p = 0; p < NB_SLAVE; p++) begin : g_port
        axi_node_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_wr_cnt (
            .clk(clk), .rst_n(rst_n), .inc_i(aw_hs_i[p]), .dec_i(b_hs_i[p]),
            .zero_o(wr_zero[p]), .err_o(wr_err[p])
        );
        axi_node_outstanding_cnt #(.MAX_OUTSTANDING(MAX_OUTSTANDING)) u_rd_cnt (
            .clk(clk), .rst_n(rst_n), .inc_i(ar_hs_i[p]), .dec_i(r_last_hs_i[p]),
            .zero_o(rd_zero[p]), .err_o(rd_err[p])
        );
    end

    // A handshake this cycle means a counter is about to move, even if the
    // wrapper has not yet reacted to block_o; do not commit until it settles.
    assign quiet = (&wr_zero) & (&rd_zero) &
                   ~(|{aw_hs_i, b_hs_i, ar_hs_i, r_last_hs_i});

    // ---------------- config port ----------------
    assign busy      = (state_q != ST_IDLE);
    assign cfg_gnt_o = cfg_req_i & (~cfg_we_i | ~busy);
    assign wr_en     = cfg_gnt_o & cfg_we_i;
    assign rd_en     = cfg_gnt_o & ~cfg_we_i;

    // Writes are only granted in IDLE, so a commit can only start from IDLE
    // and the shadow bank is frozen for the whole drain/commit.
    assign commit_req = wr_en && (cfg_idx_i == IDX_WIDTH'(CTRL_IDX)) && cfg_wdata_i[CTRL_COMMIT_BIT];
    assign err_clr    = wr_en && (cfg_idx_i == IDX_WIDTH'(STATUS_IDX)) && cfg_wdata_i[STATUS_ERR_BIT];

    always_comb begin
        rd_mux = '0;
        for (int i = 0; i < NB_MASTER; i++) begin
            if (cfg_idx_i == IDX_WIDTH'(i))             rd_mux = sh_start_q[i];
            if (cfg_idx_i == IDX_WIDTH'(NB_MASTER + i)) rd_mux = sh_end_q[i];
        end
        if (cfg_idx_i == IDX_WIDTH'(STATUS_IDX)) begin
            rd_mux[STATUS_BUSY_BIT] = busy;
            rd_mux[STATUS_ERR_BIT]  = err_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cfg_rvalid_o <= 1'b0;
            cfg_rdata_o  <= '0;
        end else begin
            cfg_rvalid_o <= cfg_gnt_o;
            cfg_rdata_o  <= rd_en ? rd_mux : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_start_q <= '1;
            sh_end_q   <= '0;
        end else if (wr_en) begin
            for (int i = 0; i < NB_MASTER; i++) begin
                if (cfg_idx_i == IDX_WIDTH'(i))             sh_start_q[i] <= cfg_wdata_i;
                if (cfg_idx_i == IDX_WIDTH'(NB_MASTER + i)) sh_end_q[i]   <= cfg_wdata_i;
            end
        end
    end

    // Sticky error; a new error in the same cycle as a clear wins.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_q <= 1'b0;
        else        err_q <= (err_q & ~err_clr) | (|{wr_err, rd_err});
    end

    // ---------------- commit sequencer ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (commit_req) state_d = ST_DRAIN;
            ST_DRAIN:  if (quiet)      state_d = ST_COMMIT;
            ST_COMMIT: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // All entries swap in one edge, so the node never sees a mixed map.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            act_start_q <= '1;
            act_end_q   <= '0;
        end else if (state_q == ST_COMMIT) begin
            act_start_q <= sh_start_q;
            act_end_q   <= sh_end_q;
        end
    end

    assign block_o      = busy;
    assign busy_o       = busy;
    assign start_addr_o = act_start_q;
    assign end_addr_o   = act_end_q;

endmodule

// File: tb/tb_axi_node_map_ctrl.sv
module tb_axi_node_map_ctrl;
    localparam int NM = 4;
    localparam int NS = 4;
    localparam int AW = 32;
    localparam int MO = 16;
    localparam int IW = 4;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            cfg_req_i = 1'b0, cfg_we_i = 1'b0;
    logic [IW-1:0]   cfg_idx_i = '0;
    logic [AW-1:0]   cfg_wdata_i = '0;
    logic            cfg_gnt_o, cfg_rvalid_o, block_o, busy_o;
    logic [AW-1:0]   cfg_rdata_o;
    logic [NS-1:0]   aw_hs_i = '0, b_hs_i = '0, ar_hs_i = '0, r_last_hs_i = '0;
    logic [NM*AW-1:0] start_addr_o, end_addr_o;

    axi_node_map_ctrl #(
        .NB_MASTER(NM), .NB_SLAVE(NS), .AXI_ADDR_WIDTH(AW),
        .MAX_OUTSTANDING(MO), .IDX_WIDTH(IW)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .cfg_req_i(cfg_req_i), .cfg_we_i(cfg_we_i), .cfg_idx_i(cfg_idx_i),
        .cfg_wdata_i(cfg_wdata_i), .cfg_gnt_o(cfg_gnt_o), .cfg_rvalid_o(cfg_rvalid_o),
        .cfg_rdata_o(cfg_rdata_o), .aw_hs_i(aw_hs_i), .b_hs_i(b_hs_i),
        .ar_hs_i(ar_hs_i), .r_last_hs_i(r_last_hs_i), .block_o(block_o),
        .start_addr_o(start_addr_o), .end_addr_o(end_addr_o), .busy_o(busy_o)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    // Phase: 0 = accepting, 1 = waiting for traffic to drain, 2 = swap cycle.
    int          m_w[NS], m_r[NS];
    logic [31:0] m_ss[NM], m_se[NM], m_as[NM], m_ae[NM];
    int          m_ph;
    bit          m_err, m_rv;
    logic [31:0] m_rd;
    bit          g_gnt;

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin m_w[i] = 0; m_r[i] = 0; end
        for (int i = 0; i < NM; i++) begin
            m_ss[i] = '1; m_as[i] = '1; m_se[i] = '0; m_ae[i] = '0;
        end
        m_ph = 0; m_err = 0; m_rv = 0; m_rd = '0;
    endtask

    function automatic int step_cnt(input int c, input bit inc, input bit dec, output bit e);
        e = 0;
        if (inc && !dec) begin if (c == MO) e = 1; else c++; end
        if (dec && !inc) begin if (c == 0) e = 1; else c--; end
        return c;
    endfunction

    // One clock: drive inputs, check grant before the edge, advance model,
    // check registered outputs just after the edge.
    task automatic cyc(input bit req, input bit we, input int idx, input logic [31:0] wd,
                       input logic [NS-1:0] aw, input logic [NS-1:0] b,
                       input logic [NS-1:0] ar, input logic [NS-1:0] rl);
        bit gnt, commit, clr, quiet, e, newerr;
        logic [31:0] rd;
        logic [127:0] es, ee;
        cfg_req_i = req; cfg_we_i = we; cfg_idx_i = idx[IW-1:0]; cfg_wdata_i = wd;
        aw_hs_i = aw; b_hs_i = b; ar_hs_i = ar; r_last_hs_i = rl;
        #1;
        gnt = req && (!we || m_ph == 0);
        g_gnt = cfg_gnt_o;
        chk("gnt", cfg_gnt_o, gnt);
        @(posedge clk);
        rd = '0; commit = 0; clr = 0;
        if (gnt && !we) begin
            if (idx < NM)          rd = m_ss[idx];
            else if (idx < 2*NM)   rd = m_se[idx-NM];
            else if (idx == 2*NM+1) rd = {30'd0, m_err, (m_ph != 0)};
        end
        if (gnt && we) begin
            if (idx < NM)          m_ss[idx] = wd;
            else if (idx < 2*NM)   m_se[idx-NM] = wd;
            else if (idx == 2*NM)   commit = wd[0];
            else if (idx == 2*NM+1) clr = wd[1];
        end
        quiet = (aw == 0) && (b == 0) && (ar == 0) && (rl == 0);
        for (int i = 0; i < NS; i++) if (m_w[i] != 0 || m_r[i] != 0) quiet = 0;
        newerr = 0;
        for (int i = 0; i < NS; i++) begin
            m_w[i] = step_cnt(m_w[i], aw[i], b[i], e);  newerr |= e;
            m_r[i] = step_cnt(m_r[i], ar[i], rl[i], e); newerr |= e;
        end
        m_err = (m_err && !clr) || newerr;
        case (m_ph)
            0: if (commit) m_ph = 1;
            1: if (quiet) m_ph = 2;
            default: begin
                for (int i = 0; i < NM; i++) begin m_as[i] = m_ss[i]; m_ae[i] = m_se[i]; end
                m_ph = 0;
            end
        endcase
        m_rv = gnt; m_rd = rd;
        #1;
        es = '0; ee = '0;
        for (int i = 0; i < NM; i++) begin es[i*32 +: 32] = m_as[i]; ee[i*32 +: 32] = m_ae[i]; end
        chk("rvalid", cfg_rvalid_o, m_rv);
        chk("rdata", cfg_rdata_o, m_rd);
        chk("block", block_o, m_ph != 0);
        chk("busy", busy_o, m_ph != 0);
        chk("start_addr", start_addr_o, es);
        chk("end_addr", end_addr_o, ee);
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc(0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    typedef struct {
        bit          we;
        int          idx;
        logic [31:0] wd;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t tbl[10];

    initial begin
        tbl[0] = '{1, 0,  32'h1000_0000, 32'h0};
        tbl[1] = '{0, 0,  32'h0,         32'h1000_0000};
        tbl[2] = '{1, 4,  32'h1FFF_FFFF, 32'h0};
        tbl[3] = '{0, 4,  32'h0,         32'h1FFF_FFFF};
        tbl[4] = '{0, 1,  32'h0,         32'hFFFF_FFFF};
        tbl[5] = '{0, 5,  32'h0,         32'h0};
        tbl[6] = '{0, 8,  32'h0,         32'h0};
        tbl[7] = '{0, 9,  32'h0,         32'h0};
        tbl[8] = '{1, 10, 32'hDEAD_BEEF, 32'h0};
        tbl[9] = '{0, 15, 32'h0,         32'h0};

        model_reset();
        @(posedge clk); #1;
        chk("rst_start", start_addr_o, {128{1'b1}});
        chk("rst_end", end_addr_o, 128'd0);
        chk("rst_block", block_o, 0);
        chk("rst_rvalid", cfg_rvalid_o, 0);
        rst_n = 1'b1;

        // register table
        foreach (tbl[i]) begin
            cyc(1, tbl[i].we, tbl[i].idx, tbl[i].wd, 0, 0, 0, 0);
            chk("tbl_rvalid", cfg_rvalid_o, 1);
            chk("tbl_rdata", cfg_rdata_o, tbl[i].exp_rd);
        end

        // idle commit: minimum latency
        cyc(1, 1, 1, 32'h1000_0000, 0, 0, 0, 0);
        cyc(1, 1, 5, 32'h1FFF_FFFF, 0, 0, 0, 0);
        cyc(1, 1, 8, 32'h1, 0, 0, 0, 0);           // T
        chk("c_block_t1", block_o, 1);
        chk("c_old_t1", start_addr_o[63:32], 32'hFFFF_FFFF);
        idle(1);                                    // T+2 (COMMIT)
        chk("c_block_t2", block_o, 1);
        chk("c_old_t2", start_addr_o[63:32], 32'hFFFF_FFFF);
        idle(1);                                    // T+3
        chk("c_block_t3", block_o, 0);
        chk("c_new_start1", start_addr_o[63:32], 32'h1000_0000);
        chk("c_new_end1", end_addr_o[63:32], 32'h1FFF_FFFF);

        // drain with 3 outstanding writes on port 2
        for (int k = 0; k < 3; k++) cyc(0, 0, 0, 0, 4'b0100, 0, 0, 0);
        cyc(1, 1, 2, 32'h2000_0000, 0, 0, 0, 0);
        cyc(1, 1, 8, 32'h1, 0, 0, 0, 0);
        idle(2);
        chk("d_block_wait", block_o, 1);
        cyc(1, 1, 3, 32'h3000_0000, 0, 0, 0, 0);
        chk("d_wr_stall", g_gnt, 0);
        cyc(1, 0, 9, 0, 0, 0, 0, 0);
        chk("d_st_gnt", g_gnt, 1);
        chk("d_status", cfg_rdata_o, 32'h1);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 4'b0100, 0, 0);
            chk("d_block_b", block_o, 1);
        end
        idle(1);
        chk("d_commit_cyc", block_o, 1);
        chk("d_old_start2", start_addr_o[95:64], 32'hFFFF_FFFF);
        idle(1);
        chk("d_done", block_o, 0);
        chk("d_new_start2", start_addr_o[95:64], 32'h2000_0000);

        // simultaneous AR and R-last with one read outstanding on port 0
        cyc(0, 0, 0, 0, 0, 0, 4'b0001, 0);
        cyc(1, 1, 8, 32'h1, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) begin
            cyc(0, 0, 0, 0, 0, 0, 4'b0001, 4'b0001);
            chk("s_block_hold", block_o, 1);
        end
        idle(2);
        chk("s_block_still", block_o, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 4'b0001);
        idle(2);
        chk("s_block_end", block_o, 0);

        // underflow error and clear
        cyc(0, 0, 0, 0, 0, 4'b1000, 0, 0);
        cyc(1, 0, 9, 0, 0, 0, 0, 0);
        chk("e_status", cfg_rdata_o, 32'h2);
        cyc(1, 1, 9, 32'h2, 0, 0, 0, 0);
        cyc(1, 0, 9, 0, 0, 0, 0, 0);
        chk("e_cleared", cfg_rdata_o, 32'h0);

        // reset mid-drain
        cyc(0, 0, 0, 0, 4'b0010, 0, 0, 0);
        cyc(1, 1, 8, 32'h1, 0, 0, 0, 0);
        idle(1);
        chk("r_in_drain", block_o, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("r_block", block_o, 0);
        chk("r_busy", busy_o, 0);
        chk("r_start", start_addr_o, {128{1'b1}});
        chk("r_end", end_addr_o, 128'd0);
        model_reset();
        cfg_req_i = 0; aw_hs_i = 0; b_hs_i = 0; ar_hs_i = 0; r_last_hs_i = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        cyc(1, 0, 9, 0, 0, 0, 0, 0);
        chk("r_status", cfg_rdata_o, 32'h0);

        // randomized traffic against the model
        for (int n = 0; n < 800; n++) begin
            bit rq, w;
            int ix;
            logic [NS-1:0] a, bb, r, l;
            rq = ($urandom % 3) == 0;
            w  = $urandom % 2;
            ix = $urandom % 16;
            if ($urandom % 4 == 0) ix = 8;
            for (int p = 0; p < NS; p++) begin
                a[p]  = ($urandom % 6) == 0;
                bb[p] = ($urandom % 6) == 0;
                r[p]  = ($urandom % 6) == 0;
                l[p]  = ($urandom % 6) == 0;
            end
            cyc(rq, w, ix, $urandom, a, bb, r, l);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
